// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift register sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;  // bits enter at the LSB
  localparam logic DIR_RIGHT = 1'b1;  // bits enter at the MSB

endpackage

// File: rtl/shift_seq_bit_counter.sv
// Down-counter tracking how many serial bits remain to be fed.
// The last flag marks the final shift so the FSM can leave SHIFT on time.
module shift_seq_bit_counter #(
  parameter int MSB = 8,
  localparam int CNT_W = $clog2(MSB + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_reg;

  // Load takes priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == CNT_W'(1));

endmodule

// File: rtl/shift_register_sequencer.sv
// Feeds a parallel word into an external bidirectional shift register one
// bit per cycle, then captures the register's parallel output as the response.
// Optional feature: define SHIFT_SEQ_PARITY_EN to add the rsp_parity output.
module shift_register_sequencer
  import shift_seq_pkg::*;
#(
  parameter int MSB = 8
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [MSB-1:0] req_data,
  input  logic           req_dir,
  output logic           sr_enable,
  output logic           sr_direction,
  output logic           sr_indata,
  input  logic [MSB-1:0] sr_outdata,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [MSB-1:0] rsp_data,
  output logic           busy
`ifdef SHIFT_SEQ_PARITY_EN
  ,
  output logic           rsp_parity
`endif
);

  localparam int CNT_W = $clog2(MSB + 1);

  state_t           state_reg, state_next;
  logic [MSB-1:0]   word_reg;
  logic             dir_reg;
  logic [MSB-1:0]   word_rev, req_rev;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last, cnt_load, cnt_dec;
  logic             accept;

  logic [MSB-1:0]   feed_word, feed_shifted;
  logic [CNT_W-1:0] feed_amt;

  logic             req_ready_reg, busy_reg, sr_enable_reg, sr_direction_reg;
  logic             sr_indata_reg, rsp_valid_reg;
  logic [MSB-1:0]   rsp_data_reg;
  logic             req_ready_next, busy_next, sr_enable_next, sr_direction_next;
  logic             sr_indata_next, rsp_valid_next;

  // Bit-reversed copies let both directions pick the next bit with the same
  // counter-derived index: left feeds word[cnt-1], right feeds word[MSB-cnt].
  genvar gi;
  generate
    for (gi = 0; gi < MSB; gi++) begin : g_rev
      assign word_rev[gi] = word_reg[MSB-1-gi];
      assign req_rev[gi]  = req_data[MSB-1-gi];
    end
  endgenerate

  assign accept = req_valid && req_ready_reg;

  shift_seq_bit_counter #(.MSB(MSB)) u_bit_counter (
    .clk      (clk),
    .resetn   (resetn),
    .load     (cnt_load),
    .load_val (CNT_W'(MSB)),
    .dec      (cnt_dec),
    .count    (cnt),
    .last     (cnt_last)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state plus next values of all registered outputs.
  always_comb begin
    state_next     = state_reg;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    feed_word      = word_reg;
    feed_amt       = '0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
          cnt_load   = 1'b1;
        end
      end
      SHIFT: begin
        cnt_dec = 1'b1;
        if (cnt_last) state_next = CAPTURE;
      end
      CAPTURE: state_next = RESP;
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Outputs are registered, so the bit presented next cycle is chosen now:
    // the first bit straight from the request, later bits from the latched word
    // one position below the current count.
    if (state_reg == IDLE) begin
      feed_word = (req_dir == DIR_RIGHT) ? req_rev : req_data;
      feed_amt  = CNT_W'(MSB - 1);
    end else begin
      feed_word = (dir_reg == DIR_RIGHT) ? word_rev : word_reg;
      feed_amt  = cnt - CNT_W'(2);
    end
    feed_shifted = feed_word >> feed_amt;

    req_ready_next    = (state_next == IDLE);
    busy_next         = (state_next != IDLE);
    sr_enable_next    = (state_next == SHIFT);
    sr_direction_next = sr_enable_next & ((state_reg == IDLE) ? req_dir : dir_reg);
    sr_indata_next    = sr_enable_next & feed_shifted[0];
    rsp_valid_next    = (state_next == RESP);
  end

  // Registered control outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_ready_reg    <= 1'b1;
      busy_reg         <= 1'b0;
      sr_enable_reg    <= 1'b0;
      sr_direction_reg <= 1'b0;
      sr_indata_reg    <= 1'b0;
      rsp_valid_reg    <= 1'b0;
    end else begin
      req_ready_reg    <= req_ready_next;
      busy_reg         <= busy_next;
      sr_enable_reg    <= sr_enable_next;
      sr_direction_reg <= sr_direction_next;
      sr_indata_reg    <= sr_indata_next;
      rsp_valid_reg    <= rsp_valid_next;
    end
  end

  // Request latch on acceptance and result capture once shifting is complete.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      word_reg     <= '0;
      dir_reg      <= DIR_LEFT;
      rsp_data_reg <= '0;
    end else begin
      if (accept) begin
        word_reg <= req_data;
        dir_reg  <= req_dir;
      end
      if (state_reg == CAPTURE) rsp_data_reg <= sr_outdata;
    end
  end

  assign req_ready    = req_ready_reg;
  assign busy         = busy_reg;
  assign sr_enable    = sr_enable_reg;
  assign sr_direction = sr_direction_reg;
  assign sr_indata    = sr_indata_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_data     = rsp_data_reg;

`ifdef SHIFT_SEQ_PARITY_EN
  logic parity_reg;

  // Parity of the accepted word, held until the next acceptance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      parity_reg <= 1'b0;
    end else if (accept) begin
      parity_reg <= ^req_data;
    end
  end

  assign rsp_parity = parity_reg;
`endif

endmodule
